// File: rtl/alu_sched.sv
// ---------------------------------------------------------------------------
// alu_sched
//
// Shares one external 8-bit combinational ALU between two requesters
// (port 0 and port 1). A round-robin arbiter picks one valid request while
// idle. The scheduler registers the winner's opcode and operands onto the ALU
// bus, gives the ALU one cycle to settle, and then captures the result into
// that port's response slot. The slot is held until the port consumes it.
//
// Sequence per operation: IDLE (accept) -> EXEC (ALU settles, capture at end)
// -> RESP (hold until rspN_ready) -> IDLE. At most one operation is in flight,
// so peak throughput is one operation every three clocks.
//
// Configuration macro:
//   ALU_SCHED_FIXED_PRIO_EN  defined   : port 0 always wins a tie. Port 1 can
//                                        starve and no grant history is kept.
//                            undefined : round-robin. When both ports request,
//                                        the port that did not win last time
//                                        is granted. Port 0 wins the first tie
//                                        after reset.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   reqN_valid/ready    N=0,1 request handshake. ready is combinational and is
//                       only ever high in IDLE, for the arbitration winner.
//   reqN_op/a/b         N=0,1 opcode and operands, sampled on accept
//   rspN_valid/ready    N=0,1 response handshake
//   rspN_ans/zero       N=0,1 captured result. Holds its value after the
//                       response is consumed.
//   alu_op/a/b          registered ALU inputs. An illegal opcode is sent as 000.
//   alu_ans/zero        combinational ALU outputs
// ---------------------------------------------------------------------------
module alu_sched #(
  parameter int                DATA_W = 8,
  parameter int                OP_W   = 3,
  parameter logic [OP_W-1:0]   OP_ILL = 3'b101
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,

  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_ans,
  output logic              rsp0_zero,

  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_ans,
  output logic              rsp1_zero,

  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_ans,
  input  logic              alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q,      state_d;
  logic                gnt_q,        gnt_d;       // port owning the in-flight op
  logic                ill_q,        ill_d;       // in-flight op had the illegal opcode
  logic [OP_W-1:0]     alu_op_q,     alu_op_d;
  logic [DATA_W-1:0]   alu_a_q,      alu_a_d;
  logic [DATA_W-1:0]   alu_b_q,      alu_b_d;
  logic                rsp0_valid_q, rsp0_valid_d;
  logic [DATA_W-1:0]   rsp0_ans_q,   rsp0_ans_d;
  logic                rsp0_zero_q,  rsp0_zero_d;
  logic                rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0]   rsp1_ans_q,   rsp1_ans_d;
  logic                rsp1_zero_q,  rsp1_zero_d;
`ifndef ALU_SCHED_FIXED_PRIO_EN
  logic                last_grant_q, last_grant_d;
`endif

  logic                idle;
  logic                grant1;      // arbitration result: 1 -> port 1 wins
  logic                accept;
  logic [OP_W-1:0]     sel_op;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic                sel_ill;
  logic [DATA_W:0]     cap;         // {zero, ans} to be captured at end of EXEC

  // The result slot receives {zero, ans}. An illegal op never reaches the
  // ALU, so whatever the ALU shows for the substituted 000 is discarded.
  function automatic logic [DATA_W:0] capture_result(
    input logic              ill,
    input logic [DATA_W-1:0] ans,
    input logic              zero
  );
    if (ill) begin
      return {1'b1, {DATA_W{1'b0}}};
    end
    return {zero, ans};
  endfunction

  // --- arbitration (combinational, only meaningful in IDLE) ---
  assign idle = (state_q == IDLE);

`ifdef ALU_SCHED_FIXED_PRIO_EN
  assign grant1 = req1_valid & ~req0_valid;
`else
  // last_grant_q == 0 means port 0 won last time, so port 1 takes the tie.
  assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);
`endif

  assign req0_ready = idle & req0_valid & ~grant1;
  assign req1_ready = idle & grant1;
  assign accept     = idle & (req0_valid | req1_valid);

  assign sel_op  = grant1 ? req1_op : req0_op;
  assign sel_a   = grant1 ? req1_a  : req0_a;
  assign sel_b   = grant1 ? req1_b  : req0_b;
  assign sel_ill = (sel_op == OP_ILL);

  assign cap = capture_result(ill_q, alu_ans, alu_zero);

  // --- next-state logic ---
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    ill_d        = ill_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp0_ans_d   = rsp0_ans_q;
    rsp0_zero_d  = rsp0_zero_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp1_ans_d   = rsp1_ans_q;
    rsp1_zero_d  = rsp1_zero_q;
`ifndef ALU_SCHED_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif

    unique case (state_q)
      // IDLE: accept the arbitration winner and drive the ALU bus.
      IDLE: begin
        if (accept) begin
          gnt_d    = grant1;
          ill_d    = sel_ill;
          alu_op_d = sel_ill ? '0 : sel_op;
          alu_a_d  = sel_a;
          alu_b_d  = sel_b;
`ifndef ALU_SCHED_FIXED_PRIO_EN
          last_grant_d = grant1;
`endif
          state_d  = EXEC;
        end
      end

      // EXEC: the ALU has settled on the registered inputs; capture its result.
      EXEC: begin
        if (gnt_q) begin
          rsp1_valid_d = 1'b1;
          rsp1_ans_d   = cap[DATA_W-1:0];
          rsp1_zero_d  = cap[DATA_W];
        end else begin
          rsp0_valid_d = 1'b1;
          rsp0_ans_d   = cap[DATA_W-1:0];
          rsp0_zero_d  = cap[DATA_W];
        end
        state_d = RESP;
      end

      // RESP: hold the response until the owning port takes it.
      RESP: begin
        if (gnt_q) begin
          if (rsp1_ready) begin
            rsp1_valid_d = 1'b0;
            state_d      = IDLE;
          end
        end else begin
          if (rsp0_ready) begin
            rsp0_valid_d = 1'b0;
            state_d      = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --- state registers ---
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= 1'b0;
      ill_q        <= 1'b0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp0_valid_q <= 1'b0;
      rsp0_ans_q   <= '0;
      rsp0_zero_q  <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_ans_q   <= '0;
      rsp1_zero_q  <= 1'b0;
`ifndef ALU_SCHED_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      ill_q        <= ill_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_ans_q   <= rsp0_ans_d;
      rsp0_zero_q  <= rsp0_zero_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_ans_q   <= rsp1_ans_d;
      rsp1_zero_q  <= rsp1_zero_d;
`ifndef ALU_SCHED_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_ans   = rsp0_ans_q;
  assign rsp0_zero  = rsp0_zero_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_ans   = rsp1_ans_q;
  assign rsp1_zero  = rsp1_zero_q;

endmodule

// File: tb/tb_alu_sched.sv
// ---------------------------------------------------------------------------
// tb_alu_sched
//
// Testbench for alu_sched.
// - A behavioural 8-bit ALU sits on the alu_* bus.
// - A driver process presents queued requests using valid/ready.
// - A negedge monitor does three things:
//     * checks both ready outputs every cycle against a protocol-level
//       arbitration model,
//     * pushes the expected result into a per-port scoreboard on each accept,
//     * pops and compares when a response appears, then checks the response
//       is held stable while waiting and keeps its value afterwards.
// Honours ALU_SCHED_FIXED_PRIO_EN in the same way as the design.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp0_valid, rsp0_ready, rsp0_zero;
  logic       rsp1_valid, rsp1_ready, rsp1_zero;
  logic [7:0] rsp0_ans, rsp1_ans;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_ans;
  logic       alu_zero;

  always #5 clk = ~clk;

  alu_sched #(.DATA_W(8), .OP_W(3), .OP_ILL(3'b101)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_ans(rsp0_ans),
    .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_ans(rsp1_ans),
    .rsp1_zero(rsp1_zero),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ans(alu_ans), .alu_zero(alu_zero)
  );

  // Behavioural ALU. BZ returns 1 when a is zero.
  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b110:  return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
      3'b111:  return (a == 8'd0) ? 8'd1 : 8'd0;
      default: return 8'hEE;
    endcase
  endfunction

  assign alu_ans  = alu_fn(alu_op, alu_a, alu_b);
  assign alu_zero = (alu_ans == 8'd0);

  typedef struct { logic [7:0] ans; logic zero; logic [2:0] op; int cyc; } exp_t;
  typedef struct { logic [2:0] op; logic [7:0] a; logic [7:0] b; } req_t;

  exp_t       sb[2][$];
  req_t       pend[2][$];
  exp_t       cur[2];
  bit         shown[2];
  bit         acc[2];
  logic [7:0] last_ans[2];
  logic       last_zero[2];
  bit         busy;
  bit         lg;
  int         gnt_log[$];
  int         n_acc = 0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  logic [1:0] rsp_v, rsp_r;
  logic [7:0] rsp_a[2];
  logic       rsp_z[2];
  assign rsp_v    = {rsp1_valid, rsp0_valid};
  assign rsp_r    = {rsp1_ready, rsp0_ready};
  assign rsp_a[0] = rsp0_ans;
  assign rsp_a[1] = rsp1_ans;
  assign rsp_z[0] = rsp0_zero;
  assign rsp_z[1] = rsp1_zero;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Record an accepted request. The expected result comes from the ALU
  // semantics; the illegal opcode yields 0 with zero set and drives 000.
  task automatic accept(input int p, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b);
    exp_t e;
    if (op == 3'b101) begin
      e.ans = 8'h00; e.zero = 1'b1; e.op = 3'b000;
    end else begin
      e.ans = alu_fn(op, a, b); e.zero = (e.ans == 8'h00); e.op = op;
    end
    e.cyc = cyc;
    sb[p].push_back(e);
    gnt_log.push_back(p);
    busy = 1'b1;
    lg   = (p == 1);
    acc[p] = 1'b1;
    n_acc++;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic e0, e1;
    if (!rst) begin
      e0 = 1'b0;
      e1 = 1'b0;
      if (!busy) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
        e1 = req1_valid & ~req0_valid;
`else
        e1 = req1_valid & (~req0_valid | ~lg);
`endif
        e0 = req0_valid & ~e1;
      end
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);

      if (req0_valid && req0_ready)      accept(0, req0_op, req0_a, req0_b);
      else if (req1_valid && req1_ready) accept(1, req1_op, req1_a, req1_b);

      for (int p = 0; p < 2; p++) begin
        if (rsp_v[p]) begin
          if (!shown[p]) begin
            chk($sformatf("rsp%0d_expected", p), (sb[p].size() != 0), 1);
            if (sb[p].size() != 0) begin
              cur[p] = sb[p].pop_front();
              chk($sformatf("rsp%0d_ans", p), rsp_a[p], cur[p].ans);
              chk($sformatf("rsp%0d_zero", p), rsp_z[p], cur[p].zero);
              chk($sformatf("rsp%0d_alu_op", p), alu_op, cur[p].op);
              chk($sformatf("rsp%0d_latency", p), cyc - cur[p].cyc, 2);
            end else begin
              cur[p].ans  = rsp_a[p];
              cur[p].zero = rsp_z[p];
            end
            shown[p] = 1'b1;
          end else begin
            chk($sformatf("rsp%0d_hold_ans", p), rsp_a[p], cur[p].ans);
            chk($sformatf("rsp%0d_hold_zero", p), rsp_z[p], cur[p].zero);
          end
          if (rsp_r[p]) begin
            shown[p]     = 1'b0;
            busy         = 1'b0;
            last_ans[p]  = rsp_a[p];
            last_zero[p] = rsp_z[p];
          end
        end else begin
          chk($sformatf("rsp%0d_sticky_ans", p), rsp_a[p], last_ans[p]);
          chk($sformatf("rsp%0d_sticky_zero", p), rsp_z[p], last_zero[p]);
        end
      end
    end
  end

  // Request driver. After an accept, the payload is scrambled so a design
  // that keeps reading the live inputs is caught.
  always @(posedge clk) begin
    req_t r;
    #1;
    if (!rst) begin
      if (acc[0]) begin
        req0_valid = 1'b0; acc[0] = 1'b0;
        req0_op = 3'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom);
      end
      if (!req0_valid && pend[0].size() != 0) begin
        r = pend[0].pop_front();
        req0_valid = 1'b1; req0_op = r.op; req0_a = r.a; req0_b = r.b;
      end
      if (acc[1]) begin
        req1_valid = 1'b0; acc[1] = 1'b0;
        req1_op = 3'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
      end
      if (!req1_valid && pend[1].size() != 0) begin
        r = pend[1].pop_front();
        req1_valid = 1'b1; req1_op = r.op; req1_a = r.a; req1_b = r.b;
      end
    end
  end

  function automatic req_t mk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_t r;
    r.op = op; r.a = a; r.b = b;
    return r;
  endfunction

  task automatic clear_model();
    for (int p = 0; p < 2; p++) begin
      sb[p].delete(); pend[p].delete();
      shown[p] = 1'b0; acc[p] = 1'b0; last_ans[p] = 8'h00; last_zero[p] = 1'b0;
    end
    busy = 1'b0; lg = 1'b1; gnt_log.delete();
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  // Pulse reset starting #1 after a rising edge. Optionally check that every
  // output is cleared while reset is held.
  task automatic do_reset(input bit check_outs);
    @(posedge clk); #1;
    rst = 1'b1;
    clear_model();
    @(negedge clk);
    if (check_outs) begin
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_rsp0_valid", rsp0_valid, 0);
      chk("rst_rsp1_valid", rsp1_valid, 0);
      chk("rst_rsp0_ans",   rsp0_ans, 0);
      chk("rst_rsp1_ans",   rsp1_ans, 0);
      chk("rst_rsp0_zero",  rsp0_zero, 0);
      chk("rst_rsp1_zero",  rsp1_zero, 0);
      chk("rst_alu_op",     alu_op, 0);
      chk("rst_alu_a",      alu_a, 0);
      chk("rst_alu_b",      alu_b, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < 300 && !(pend[0].size() == 0 && pend[1].size() == 0 && !req0_valid &&
                            !req1_valid && sb[0].size() == 0 && sb[1].size() == 0 && !busy));
    chk("idle_reached", (n < 300), 1);
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.op = 3'($urandom_range(0, 7));
    r.a  = 8'($urandom);
    r.b  = ($urandom_range(0, 3) == 0) ? r.a : 8'($urandom);
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_g[4];
    int n0;
    int n;
    rst = 1'b1;
    req0_valid = 1'b0; req0_op = 3'd0; req0_a = 8'd0; req0_b = 8'd0;
    req1_valid = 1'b0; req1_op = 3'd0; req1_a = 8'd0; req1_b = 8'd0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    do_reset(1'b1);

    // Single ADD
    @(negedge clk);
    pend[0].push_back(mk(3'b000, 8'hF0, 8'h20));
    wait_idle();
    chk("single_ans", last_ans[0], 8'h10);
    chk("single_zero", last_zero[0], 0);

    // Tie from reset
    do_reset(1'b0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      pend[0].push_back(mk(3'b001, 8'd5, 8'd5));
      pend[1].push_back(mk(3'b011, 8'd1, 8'd2));
    end
    wait_idle();
`ifdef ALU_SCHED_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 4; i++)
      chk($sformatf("tie_grant%0d", i), (gnt_log.size() > i) ? gnt_log[i] : -1, exp_g[i]);
    chk("tie_rsp0_ans", last_ans[0], 8'h00);
    chk("tie_rsp0_zero", last_zero[0], 1);
    chk("tie_rsp1_ans", last_ans[1], 8'h03);

    // Backpressure on port 1 while port 0 waits
    @(posedge clk); #1;
    rsp1_ready = 1'b0;
    @(negedge clk);
    pend[1].push_back(mk(3'b100, 8'hAA, 8'hFF));
    @(negedge clk);
    pend[0].push_back(mk(3'b000, 8'd3, 8'd4));
    n = 0;
    while (!rsp1_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp1_seen", (n < 20), 1);
    repeat (5) @(posedge clk);
    #1;
    rsp1_ready = 1'b1;
    wait_idle();
    chk("bp_rsp1_ans", last_ans[1], 8'h55);
    chk("bp_rsp0_ans", last_ans[0], 8'h07);

    // Illegal opcode
    @(negedge clk);
    pend[0].push_back(mk(3'b101, 8'd7, 8'd9));
    wait_idle();
    chk("ill_ans", last_ans[0], 8'h00);
    chk("ill_zero", last_zero[0], 1);
    chk("ill_alu_op", alu_op, 3'b000);

    // Reset while EXEC: the operation is dropped, and the next tie goes to port 0
    @(negedge clk);
    pend[0].push_back(mk(3'b000, 8'd1, 8'd1));
    n0 = n_acc;
    n = 0;
    while (n_acc == n0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_accepted", (n < 20), 1);
    do_reset(1'b1);
    @(negedge clk);
    pend[0].push_back(mk(3'b010, 8'hF0, 8'h3C));
    pend[1].push_back(mk(3'b110, 8'h80, 8'h01));
    wait_idle();
    chk("midrst_first_grant", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);
    chk("midrst_rsp0_ans", last_ans[0], 8'h30);
    chk("midrst_rsp1_ans", last_ans[1], 8'h01);

    // Randomized traffic with random response backpressure
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      if (pend[0].size() < 2 && $urandom_range(0, 2) == 0) pend[0].push_back(rand_req());
      if (pend[1].size() < 2 && $urandom_range(0, 2) == 0) pend[1].push_back(rand_req());
    end
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
